// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the RAM-side bus of ram_arbiter.
// The arbiter connects through the slave modport; requesters and the RAM use master.
interface ram_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              done_a;
    logic [DATA_W-1:0] rdata_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              done_b;
    logic [DATA_W-1:0] rdata_b;

    logic              busy;

    logic              ram_ena;
    logic              ram_wena;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  ram_rdata,
        output done_a, rdata_a, done_b, rdata_b, busy,
        output ram_ena, ram_wena, ram_addr, ram_wdata
    );

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output ram_rdata,
        input  done_a, rdata_a, done_b, rdata_b, busy,
        input  ram_ena, ram_wena, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port synchronous RAM.
// Each grant runs IDLE -> ACCESS -> RESP: one RAM cycle, then a done pulse
// to the served port while ram_rdata is passed straight through.
module ram_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    state_t            state_nxt;

    // last_grant_b = 1 means port B was served last, so A wins the next tie
    logic              last_grant_b;
    logic              last_grant_b_nxt;
    logic              grant_any;
    logic              grant_b;

    logic              ram_ena_q,   ram_ena_nxt;
    logic              ram_wena_q,  ram_wena_nxt;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_nxt;
    logic              done_a_q,    done_a_nxt;
    logic              done_b_q,    done_b_nxt;

    // Round-robin pick: a lone request wins, a tie goes to the port not served last
    always_comb begin
        grant_any = bus.req_a | bus.req_b;
        grant_b   = bus.req_b & (~bus.req_a | ~last_grant_b);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = grant_any ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the grant history
    always_comb begin
        ram_ena_nxt      = ram_ena_q;
        ram_wena_nxt     = ram_wena_q;
        ram_addr_nxt     = ram_addr_q;
        ram_wdata_nxt    = ram_wdata_q;
        done_a_nxt       = 1'b0;
        done_b_nxt       = 1'b0;
        last_grant_b_nxt = last_grant_b;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    ram_ena_nxt      = 1'b1;
                    ram_wena_nxt     = grant_b ? bus.we_b    : bus.we_a;
                    ram_addr_nxt     = grant_b ? bus.addr_b  : bus.addr_a;
                    ram_wdata_nxt    = grant_b ? bus.wdata_b : bus.wdata_a;
                    last_grant_b_nxt = grant_b;
                end
            end
            ACCESS: begin
                ram_ena_nxt  = 1'b0;
                ram_wena_nxt = 1'b0;
                ram_addr_nxt = '0;
                done_a_nxt   = ~last_grant_b;
                done_b_nxt   = last_grant_b;
            end
            default: begin
                done_a_nxt = 1'b0;
                done_b_nxt = 1'b0;
            end
        endcase
    end

    // Output registers; reset abandons any in-flight access immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ena_q    <= 1'b0;
            ram_wena_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            done_a_q     <= 1'b0;
            done_b_q     <= 1'b0;
            last_grant_b <= 1'b1;
        end else begin
            ram_ena_q    <= ram_ena_nxt;
            ram_wena_q   <= ram_wena_nxt;
            ram_addr_q   <= ram_addr_nxt;
            ram_wdata_q  <= ram_wdata_nxt;
            done_a_q     <= done_a_nxt;
            done_b_q     <= done_b_nxt;
            last_grant_b <= last_grant_b_nxt;
        end
    end

    assign bus.ram_ena   = ram_ena_q;
    assign bus.ram_wena  = ram_wena_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.done_a    = done_a_q;
    assign bus.done_b    = done_b_q;
    assign bus.busy      = (state != IDLE);
    assign bus.rdata_a   = bus.ram_rdata;
    assign bus.rdata_b   = bus.ram_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed stimulus queues the expected done
// (port, cycle, read data) and a negedge monitor pops and compares each done.
module tb_ram_arbiter;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct {
        bit          port_b;
        bit          is_read;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];
    logic [DATA_W-1:0] mem [32];

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Cycle counter, read on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous RAM model
    always @(posedge clk) begin
        if (bus.ram_ena) begin
            if (bus.ram_wena) mem[bus.ram_addr] <= bus.ram_wdata;
            else              bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic expect_done(input bit pb, input bit rd, input logic [31:0] d, input int c);
        exp_t e;
        e.port_b  = pb;
        e.is_read = rd;
        e.data    = d;
        e.cyc     = c;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && (bus.done_a === 1'b1 || bus.done_b === 1'b1)) begin
            check("done_exclusive", {31'b0, bus.done_a & bus.done_b}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got done_a=%b done_b=%b expected none (cycle %0d)",
                         bus.done_a, bus.done_b, cyc);
            end else begin
                e = sb.pop_front();
                check("done_port_b", {31'b0, bus.done_b}, {31'b0, e.port_b});
                check("done_cycle", cyc, e.cyc);
                if (e.is_read)
                    check("rdata", e.port_b ? bus.rdata_b : bus.rdata_a, e.data);
            end
        end
    end

    initial begin
        int c;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[5] = 32'hDEADBEEF;
        bus.req_a = 0; bus.we_a = 0; bus.addr_a = '0; bus.wdata_a = '0;
        bus.req_b = 0; bus.we_b = 0; bus.addr_b = '0; bus.wdata_b = '0;

        // Reset values
        @(negedge clk);
        check("rst_ram_ena",   {31'b0, bus.ram_ena},  32'd0);
        check("rst_ram_wena",  {31'b0, bus.ram_wena}, 32'd0);
        check("rst_ram_addr",  {27'b0, bus.ram_addr}, 32'd0);
        check("rst_ram_wdata", bus.ram_wdata,         32'd0);
        check("rst_done_a",    {31'b0, bus.done_a},   32'd0);
        check("rst_done_b",    {31'b0, bus.done_b},   32'd0);
        check("rst_busy",      {31'b0, bus.busy},     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read on A
        c = cyc;
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 5; bus.wdata_a = 32'hA5A5A5A5;
        expect_done(0, 1, 32'hDEADBEEF, c + 2);
        check("t1_idle_ena", {31'b0, bus.ram_ena}, 32'd0);
        @(negedge clk);
        check("t1_acc_ena",  {31'b0, bus.ram_ena},  32'd1);
        check("t1_acc_wena", {31'b0, bus.ram_wena}, 32'd0);
        check("t1_acc_addr", {27'b0, bus.ram_addr}, 32'd5);
        check("t1_acc_busy", {31'b0, bus.busy},     32'd1);
        bus.addr_a = 7;
        @(negedge clk);
        check("t1_resp_ena",  {31'b0, bus.ram_ena},  32'd0);
        check("t1_resp_addr", {27'b0, bus.ram_addr}, 32'd0);
        check("t1_resp_busy", {31'b0, bus.busy},     32'd1);
        bus.req_a = 0;
        @(negedge clk);
        check("t1_after_busy", {31'b0, bus.busy}, 32'd0);

        // Write then read on B, addr 31
        c = cyc;
        bus.req_b = 1; bus.we_b = 1; bus.addr_b = 31; bus.wdata_b = 32'h12345678;
        expect_done(1, 0, 32'h0, c + 2);
        @(negedge clk);
        check("t2_w_ena",   {31'b0, bus.ram_ena},  32'd1);
        check("t2_w_wena",  {31'b0, bus.ram_wena}, 32'd1);
        check("t2_w_addr",  {27'b0, bus.ram_addr}, 32'd31);
        check("t2_w_wdata", bus.ram_wdata,         32'h12345678);
        @(negedge clk);
        check("t2_resp_wena", {31'b0, bus.ram_wena}, 32'd0);
        bus.we_b = 0; bus.wdata_b = '0;
        expect_done(1, 1, 32'h12345678, c + 5);
        @(negedge clk);
        check("t2_idle_ena", {31'b0, bus.ram_ena}, 32'd0);
        @(negedge clk);
        check("t2_r_ena",  {31'b0, bus.ram_ena},  32'd1);
        check("t2_r_wena", {31'b0, bus.ram_wena}, 32'd0);
        check("t2_r_addr", {27'b0, bus.ram_addr}, 32'd31);
        @(negedge clk);
        bus.req_b = 0;
        @(negedge clk);

        // Contention straight after reset: A, B, A, B
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        c = cyc;
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 5;
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 31;
        expect_done(0, 1, 32'hDEADBEEF, c + 2);
        expect_done(1, 1, 32'h12345678, c + 5);
        expect_done(0, 1, 32'hDEADBEEF, c + 8);
        expect_done(1, 1, 32'h12345678, c + 11);
        repeat (11) @(negedge clk);
        bus.req_a = 0; bus.req_b = 0;
        @(negedge clk);

        // Late request from B while A is in ACCESS
        c = cyc;
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 5;
        expect_done(0, 1, 32'hDEADBEEF, c + 2);
        @(negedge clk);
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 31;
        expect_done(1, 1, 32'h12345678, c + 5);
        @(negedge clk);
        bus.req_a = 0;
        repeat (3) @(negedge clk);
        bus.req_b = 0;
        @(negedge clk);

        // Reset during ACCESS of a write to addr 3
        c = cyc;
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 3; bus.wdata_a = 32'hFFFFFFFF;
        @(negedge clk);
        check("t5_acc_ena",  {31'b0, bus.ram_ena},  32'd1);
        check("t5_acc_wena", {31'b0, bus.ram_wena}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ena",    {31'b0, bus.ram_ena},  32'd0);
        check("t5_rst_wena",   {31'b0, bus.ram_wena}, 32'd0);
        check("t5_rst_addr",   {27'b0, bus.ram_addr}, 32'd0);
        check("t5_rst_done_a", {31'b0, bus.done_a},   32'd0);
        check("t5_rst_busy",   {31'b0, bus.busy},     32'd0);
        bus.req_a = 0; bus.we_a = 0;
        @(negedge clk);
        check("t5_mem3", mem[3], 32'd0);
        rst_n = 1'b1;
        c = cyc;
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 5;
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 31;
        expect_done(0, 1, 32'hDEADBEEF, c + 2);
        expect_done(1, 1, 32'h12345678, c + 5);
        repeat (2) @(negedge clk);
        bus.req_a = 0;
        repeat (3) @(negedge clk);
        bus.req_b = 0;
        @(negedge clk);

        // Request pulse that never sees a rising edge
        @(posedge clk);
        #1;
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 5;
        @(negedge clk);
        bus.req_a = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_ena",  {31'b0, bus.ram_ena}, 32'd0);
            check("t6_busy", {31'b0, bus.busy},    32'd0);
        end

        @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
